// File: rtl/dummy_accelerator_pkg.sv
// Shared types and default sizing for the dummy accelerator scheduler slice.
package dummy_accelerator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  localparam int DUMMY_ACC_NUM_REQ = 4;
  localparam int DUMMY_ACC_DATA_W  = 64;
  localparam int DUMMY_ACC_CTL_W   = 8;

endpackage

// File: rtl/dummy_accelerator_rr_picker.sv
// Round-robin picker: first set request at or above rr_ptr_i, wrapping around.
module dummy_accelerator_rr_picker
  import dummy_accelerator_pkg::*;
#(
  parameter  int NUM_REQ = DUMMY_ACC_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               grant_valid_o
);

  logic [2*NUM_REQ-1:0] dbl_req;
  logic [2*NUM_REQ-1:0] low_mask;
  logic [2*NUM_REQ-1:0] masked_req;

  // The upper copy of the requests is never masked, so it supplies the wrap-around.
  always_comb begin
    dbl_req       = {req_i, req_i};
    low_mask      = ((2*NUM_REQ)'(1) << rr_ptr_i) - (2*NUM_REQ)'(1);
    masked_req    = dbl_req & ~low_mask;
    grant_o       = '0;
    grant_valid_o = 1'b0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (masked_req[i]) begin
        grant_valid_o = 1'b1;
        grant_o       = (i >= NUM_REQ) ? IDX_W'(i - NUM_REQ) : IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dummy_accelerator_rr_scheduler.sv
// Round-robin sharing of one iterative accelerator between NUM_REQ requesters.
// Handshakes: a transfer completes in a cycle where valid and ready are both high.
module dummy_accelerator_rr_scheduler
  import dummy_accelerator_pkg::*;
#(
  parameter  int NUM_REQ = DUMMY_ACC_NUM_REQ,
  parameter  int DATA_W  = DUMMY_ACC_DATA_W,
  parameter  int CTL_W   = DUMMY_ACC_CTL_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0][CTL_W-1:0]   req_ctl_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [DATA_W-1:0]               rsp_data_o,
  output logic                            acc_valid_o,
  input  logic                            acc_ready_i,
  output logic [DATA_W-1:0]               acc_data_o,
  output logic [CTL_W-1:0]                acc_ctl_o,
  input  logic                            acc_valid_i,
  output logic                            acc_ready_o,
  input  logic [DATA_W-1:0]               acc_data_i,
  output logic                            acc_flush_o,
  output logic                            busy_o,
  output logic [IDX_W-1:0]                owner_o
);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic [IDX_W-1:0] grant;
  logic             grant_valid;

  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               acc_valid;
  logic               acc_ready;
  logic [DATA_W-1:0]  acc_data;
  logic [CTL_W-1:0]   acc_ctl;
  logic               busy;

  dummy_accelerator_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i         (req_valid_i),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    req_ready = '0;
    rsp_valid = '0;
    acc_valid = 1'b0;
    acc_ready = 1'b0;
    acc_data  = '0;
    acc_ctl   = '0;
    case (state_q)
      IDLE: begin
        acc_valid = grant_valid;
        if (grant_valid) begin
          acc_data         = req_data_i[grant];
          acc_ctl          = req_ctl_i[grant];
          req_ready[grant] = acc_ready_i;
        end
        if (grant_valid && acc_ready_i) begin
          owner_d  = grant;
          rr_ptr_d = (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + IDX_W'(1);
          state_d  = BUSY;
          // A ctl=0 op can answer in the issue cycle; finish here if the owner takes it.
          if (acc_valid_i) begin
            rsp_valid[grant] = 1'b1;
            acc_ready        = rsp_ready_i[grant];
            if (rsp_ready_i[grant]) state_d = IDLE;
          end
        end
      end
      BUSY: begin
        rsp_valid[owner_q] = acc_valid_i;
        acc_ready          = rsp_ready_i[owner_q];
        if (acc_valid_i && rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d   = IDLE;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      req_ready = '0;
      rsp_valid = '0;
      acc_valid = 1'b0;
      acc_ready = 1'b0;
    end
    busy = (state_q == BUSY) || (acc_valid && acc_ready_i);
  end

  // Reset forces every output low, including the purely combinational paths.
  assign req_ready_o = rst_i ? '0 : req_ready;
  assign rsp_valid_o = rst_i ? '0 : rsp_valid;
  assign rsp_data_o  = rst_i ? '0 : acc_data_i;
  assign acc_valid_o = rst_i ? 1'b0 : acc_valid;
  assign acc_data_o  = rst_i ? '0 : acc_data;
  assign acc_ctl_o   = rst_i ? '0 : acc_ctl;
  assign acc_ready_o = rst_i ? 1'b0 : acc_ready;
  assign acc_flush_o = flush_i & ~rst_i;
  assign busy_o      = rst_i ? 1'b0 : busy;
  assign owner_o     = rst_i ? '0 : owner_q;

endmodule

// File: doc/dummy_accelerator_rr_scheduler.md
Name: dummy_accelerator_rr_scheduler

Overview:
- Shares one iterative dummy accelerator between NUM_REQ requesters (e.g. several issue ports or CPU-side queues).
- Grants the accelerator round-robin and forwards the winner's operands and ctl value.
- Owns the accelerator until its result handshake completes, then routes the result back to the owning requester only.
- Sits between the requesters and the accelerator's valid/ready request and response interfaces.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 64, operand/result width.
- CTL_W, 8, width of the ctl (latency) field passed to the accelerator.
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush; abort the in-flight operation.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester operation accepted.
- req_data_i  in  NUM_REQ x DATA_W  operands.
- req_ctl_i  in  NUM_REQ x CTL_W  ctl value per requester.
- rsp_valid_o  out  NUM_REQ  result valid, one-hot to the owner.
- rsp_ready_i  in  NUM_REQ  per-requester result ready.
- rsp_data_o  out  DATA_W  result data, shared by all requesters.
- acc_valid_o  out  1  request valid to the accelerator.
- acc_ready_i  in  1  accelerator ready.
- acc_data_o  out  DATA_W  operands to the accelerator.
- acc_ctl_o  out  CTL_W  ctl value to the accelerator.
- acc_valid_i  in  1  accelerator result valid.
- acc_ready_o  out  1  result ready to the accelerator.
- acc_data_i  in  DATA_W  accelerator result.
- acc_flush_o  out  1  flush to the accelerator; equals flush_i.
- busy_o  out  1  accelerator owned (state BUSY, or issue in progress).
- owner_o  out  IDX_W  index of the current/last owner.

Behaviour:
- States: IDLE, BUSY. Registers: state, rr_ptr (IDX_W bits), owner (IDX_W bits).
- Reset values: state=IDLE, rr_ptr=0, owner=0.
- While rst_i is high, all outputs are 0 (combinational paths included).

IDLE:
- grant = first set bit of req_valid_i, searching from rr_ptr upward with wrap-around (picker sub-module).
- acc_valid_o = |req_valid_i.
- acc_data_o and acc_ctl_o come from the granted requester; both are 0 when no requester is valid.
- req_ready_o[grant] = acc_ready_i; all other req_ready_o bits are 0.
- On issue handshake (acc_valid_o && acc_ready_i): owner <= grant; rr_ptr <= grant+1, wrapping at NUM_REQ-1 -> 0.
- Same-cycle (combinational, ctl=0) result:
  - acc_valid_i=1 in the issue cycle gives rsp_valid_o[grant]=1 and acc_ready_o=rsp_ready_i[grant].
  - If rsp_ready_i[grant]=1, the operation completes with zero latency; stay in IDLE.
  - Otherwise go to BUSY; the accelerator holds the result in its wait-for-core state.
- Issue handshake without acc_valid_i -> BUSY.
- No handshake -> stay IDLE; rr_ptr unchanged.

BUSY:
- acc_valid_o=0; all req_ready_o=0.
- rsp_valid_o[owner] = acc_valid_i; rsp_data_o = acc_data_i; acc_ready_o = rsp_ready_i[owner].
- Result handshake -> IDLE; a new grant is possible in the next cycle, so back-to-back throughput is 1 op per 2 cycles for multicycle ops.
- rsp_ready_i of non-owners is ignored.
- busy_o = 1.

Common rules:
- rsp_data_o = acc_data_i in every state; only rsp_valid_o is gated.
- Fairness: a requester that holds valid is granted within NUM_REQ issues.
- Requesters must keep req_valid_i, req_data_i and req_ctl_i stable until req_ready_o; the scheduler does not check this.
- flush_i=1 has priority over everything:
  - state <= IDLE; rr_ptr and owner unchanged.
  - No handshakes complete in that cycle: req_ready_o=0, rsp_valid_o=0, acc_valid_o=0, acc_ready_o=0.
  - acc_flush_o=1 in that cycle.
- Reset mid-operation: returns to IDLE immediately, asynchronously.

Decomposition:
- Package dummy_accelerator_pkg: sched_state_t enum {IDLE, BUSY}; default constants DUMMY_ACC_NUM_REQ, DUMMY_ACC_DATA_W, DUMMY_ACC_CTL_W.
- Sub-module dummy_accelerator_rr_picker: purely combinational.
  - Inputs: NUM_REQ-wide req vector and rr_ptr.
  - Outputs: grant index plus grant_valid.
  - Implementation: double-width masked priority encode.

Test Plan:
- Reset, then requester 2 only, ctl=3, acc result 3 cycles later, rsp_ready=1 -> owner_o=2; rsp_valid_o=4'b0100 for 1 cycle; rsp_data_o=acc_data_i; rr_ptr=3; back in IDLE.
- All 4 requesters valid continuously, single-cycle accelerator -> grant order 0,1,2,3,0,1; every req_ready_o pulse is one-hot.
- ctl=0 combinational op: acc_valid_i in the issue cycle, rsp_ready=1 -> zero-latency completion; stays IDLE; next grant on the following cycle.
- Same as above but rsp_ready=0 for 5 cycles -> BUSY; rsp_valid_o held for 5 cycles; acc_ready_o=0 throughout; completes on the cycle rsp_ready rises.
- In BUSY with owner=1, assert rsp_ready_i[0] and rsp_ready_i[3] only -> acc_ready_o stays 0; no completion.
- flush_i during BUSY (owner=3, rr_ptr=0) -> acc_flush_o=1, next state IDLE, rr_ptr still 0; a later valid from requester 0 is granted first.
- Assert rst_i asynchronously mid-BUSY -> all outputs 0 immediately; after release rr_ptr=0, owner=0, state=IDLE.
